cpa_share_arb: RTL and testbench

CPA_SHARE_ARB -- requirements
Module: cpa_share_arb

---
 rtl/cpa_share_arb.sv | 128 ++++++++++++
 tb/tb_cpa_share_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpa_share_arb.sv
// Shares one MG_CPA adder among NREQ requesters; round-robin grant, or fixed priority with CPA_ARB_FIXED_PRIO_EN.
// Latency 1 cycle to a registered result; requests stall while a held result is not consumed.

module mg_cpa (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module cpa_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [15:0]        rsp_sum,
  output logic               rsp_cout,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        op_count
);

  logic            rsp_valid_q;
  logic [15:0]     rsp_sum_q;
  logic            rsp_cout_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [15:0]     op_count_q;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            found;
  int              idx;
  logic            slot_free;
  logic            xfer;
  logic [15:0]     mux_a, mux_b;
  logic [15:0]     cpa_sum;
  logic            cpa_cout;

`ifndef CPA_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
`endif

  // Walk the requesters starting at the search origin; the first valid one wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef CPA_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr_q) + k) % NREQ;
`endif
      if (!found && req_valid[idx]) begin
        found        = 1'b1;
        gnt_oh[idx]  = 1'b1;
        gnt_idx      = idx[IDW-1:0];
      end
    end
  end

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign req_ready = (slot_free && !rst) ? gnt_oh : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      mux_a = mux_a | (req_a[16*i +: 16] & {16{gnt_oh[i]}});
      mux_b = mux_b | (req_b[16*i +: 16] & {16{gnt_oh[i]}});
    end
  end

  mg_cpa u_cpa (
    .a    (mux_a),
    .b    (mux_b),
    .sum  (cpa_sum),
    .cout (cpa_cout)
  );

`ifndef CPA_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  // A new transfer takes precedence over a consume so back-to-back ops keep rsp_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      op_count_q  <= '0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_sum_q   <= cpa_sum;
      rsp_cout_q  <= cpa_cout;
      rsp_id_q    <= gnt_idx;
      op_count_q  <= op_count_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_cpa_share_arb.sv
// Directed bench for cpa_share_arb: single op, carry, backpressure, reset, fairness and counter wrap.

module tb_cpa_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a, req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [15:0]        rsp_sum;
  logic               rsp_cout;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        op_count;

  int errors = 0;
  int checks = 0;

  cpa_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef CPA_ARB_FIXED_PRIO_EN
  localparam logic [3:0]  BP_GNT = 4'b0001;
  localparam logic [1:0]  BP_ID  = 2'd0;
  localparam logic [15:0] BP_SUM = 16'h0111;
`else
  localparam logic [3:0]  BP_GNT = 4'b0100;
  localparam logic [1:0]  BP_ID  = 2'd2;
  localparam logic [15:0] BP_SUM = 16'h0333;
`endif

  initial begin
    logic [1:0] exp_id;
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_sum", 32'(rsp_sum), 32'h0);
    chk("rst_count", 32'(op_count), 32'h0);

    // Single op from requester 0
    rst = 1'b0;
    req_valid = 4'b0001;
    req_a[15:0] = 16'h1234;
    req_b[15:0] = 16'h0FFF;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_sum", 32'(rsp_sum), 32'h2233);
    chk("single_cout", 32'(rsp_cout), 32'h0);
    chk("single_id", 32'(rsp_id), 32'h0);
    chk("single_count", 32'(op_count), 32'h1);

    // Carry-out from requester 2
    req_valid = 4'b0100;
    req_a[47:32] = 16'hFFFF;
    req_b[47:32] = 16'h0001;
    #1;
    chk("carry_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("carry_valid", 32'(rsp_valid), 32'h1);
    chk("carry_sum", 32'(rsp_sum), 32'h0);
    chk("carry_cout", 32'(rsp_cout), 32'h1);
    chk("carry_id", 32'(rsp_id), 32'h2);
    chk("carry_count", 32'(op_count), 32'h2);
    tick();
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: a_i = 0x100*(i+1), b_i = 0x11*(i+1)
    req_a = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    req_b = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      chk("bp_hold_sum", 32'(rsp_sum), 32'h0222);
      chk("bp_hold_id", 32'(rsp_id), 32'h1);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      tick();
    end
    chk("bp_hold_count", 32'(op_count), 32'h3);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'(BP_GNT));
    tick();
    chk("bp_new_valid", 32'(rsp_valid), 32'h1);
    chk("bp_new_id", 32'(rsp_id), 32'(BP_ID));
    chk("bp_new_sum", 32'(rsp_sum), 32'(BP_SUM));
    chk("bp_new_count", 32'(op_count), 32'h4);

    // Reset while a result is held
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_count", 32'(op_count), 32'h0);
    chk("midrst_sum", 32'(rsp_sum), 32'h0);

    // Fairness with all requesters continuously valid
    req_valid = 4'b1111;
    #1;
    chk("fair_first_ready", 32'(req_ready), 32'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
`ifdef CPA_ARB_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = 2'(c % 4);
`endif
      chk("fair_id", 32'(rsp_id), 32'(exp_id));
      chk("fair_valid", 32'(rsp_valid), 32'h1);
    end
    chk("fair_count", 32'(op_count), 32'h5);

    // Counter wrap: 65530 more transfers reach 0xFFFF
    repeat (65530) @(posedge clk);
    #1;
    chk("wrap_max", 32'(op_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(op_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
